// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling constants.
// Shared by the receiver, transmitter and baud generator.
// Contains no logic and therefore has no latency or backpressure.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_TICK   = 7;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level input; both flops reset high.
// Latency: 2 PCLK.
// Backpressure: none; the output is a continuous level.
module uart_sync2 (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_sync.sv
// 16x-oversampling UART receiver: start/data/stop framing with glitch rejection.
// Latency: rx_done/frame_err fire one PCLK after the mid-stop-bit sampling tick.
// Backpressure: none; results are pulses and a held byte that the consumer must catch.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             s_tick,
    input  logic             rx,
    output logic [DBITS-1:0] rx_dout,
    output logic             rx_done,
    output logic             frame_err,
    output logic             rx_busy
);

    localparam int BCW = (DBITS > 1) ? $clog2(DBITS) : 1;

    logic             rx_s;
    uart_state_e      state_q, state_d;
    logic [3:0]       tick_q, tick_d;
    logic [BCW-1:0]   bit_q, bit_d;
    logic [DBITS-1:0] sh_q, sh_d;
    logic [DBITS-1:0] dout_q, dout_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;

    uart_sync2 u_sync (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .d       (rx),
        .q       (rx_s)
    );

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            // Start detection runs every PCLK so a frame right after the stop sample is not missed.
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == 4'(MID_TICK)) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == 4'(OVERSAMPLE - 1)) begin
                        tick_d = '0;
                        sh_d   = {rx_s, sh_q[DBITS-1:1]};
                        if (bit_q == BCW'(DBITS - 1)) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_q == 4'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        tick_d  = '0;
                        if (rx_s) begin
                            dout_d = sh_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_dout   = dout_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sync.sv
// Scoreboard bench for uart_rx_sync: frames queue their expected outcome, the monitor pops on each pulse.
module tb_uart_rx_sync;

    logic       PCLK    = 1'b0;
    logic       PRESETn = 1'b0;
    logic       s_tick  = 1'b0;
    logic       rx      = 1'b1;
    logic [7:0] rx_dout;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    typedef struct packed {
        logic       is_err;
        logic [7:0] dat;
    } exp_t;

    exp_t       sb[$];
    int         n_chk    = 0;
    int         n_fail   = 0;
    logic [7:0] exp_dout = 8'h00;
    bit         tick_en  = 1'b1;
    int         tick_cnt = 0;
    logic       prev_any = 1'b0;

    uart_rx_sync #(.DBITS(8), .SB_TICK(16)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .s_tick    (s_tick),
        .rx        (rx),
        .rx_dout   (rx_dout),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // s_tick every 4 PCLK, so one nominal bit is 64 PCLK.
    initial begin
        forever begin
            @(negedge PCLK);
            tick_cnt = (tick_cnt == 3) ? 0 : tick_cnt + 1;
            s_tick   = tick_en && (tick_cnt == 0);
        end
    end

    always @(negedge PCLK) begin
        exp_t e;
        if (rx_done || frame_err) begin
            check_eq("pulse_excl", {30'b0, rx_done & frame_err, prev_any}, 32'd0);
            if (sb.size() == 0) begin
                check_eq("unexpected_pulse", {30'b0, rx_done, frame_err}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("pulse_kind", {30'b0, rx_done, frame_err}, {30'b0, ~e.is_err, e.is_err});
                check_eq("rx_dout", {24'b0, rx_dout}, {24'b0, e.dat});
            end
        end
        prev_any <= rx_done || frame_err;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    // A bad stop stays low just past its midpoint so the re-entered START sees the line high again.
    task automatic send_frame(input logic [7:0] d, input int bc, input bit stop_ok);
        if (stop_ok) begin
            sb.push_back({1'b0, d});
            exp_dout = d;
        end else begin
            sb.push_back({1'b1, exp_dout});
        end
        rx = 1'b0;
        cyc(bc);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            cyc(bc);
        end
        if (stop_ok) begin
            rx = 1'b1;
            cyc(bc);
        end else begin
            rx = 1'b0;
            cyc(bc / 2 + 12);
            rx = 1'b1;
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((sb.size() != 0 || rx_busy) && n < max_cyc) begin
            cyc(1);
            n++;
        end
        check_eq("drain_sb", sb.size(), 32'd0);
        check_eq("drain_idle", {31'b0, rx_busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] abort_d;
        abort_d = 8'hE7;

        PRESETn = 1'b0;
        rx      = 1'b1;
        cyc(5);
        check_eq("rst_dout", {24'b0, rx_dout}, 32'd0);
        check_eq("rst_done", {31'b0, rx_done}, 32'd0);
        check_eq("rst_ferr", {31'b0, frame_err}, 32'd0);
        check_eq("rst_busy", {31'b0, rx_busy}, 32'd0);
        PRESETn = 1'b1;
        cyc(10);

        send_frame(8'h55, 64, 1'b1);
        drain(300);
        check_eq("dout_55", {24'b0, rx_dout}, 32'h55);

        // Start glitch of 4 s_ticks must be rejected at mid start bit.
        rx = 1'b0;
        cyc(8);
        check_eq("glitch_busy", {31'b0, rx_busy}, 32'd1);
        cyc(8);
        rx = 1'b1;
        cyc(60);
        check_eq("glitch_idle", {31'b0, rx_busy}, 32'd0);
        check_eq("glitch_dout", {24'b0, rx_dout}, 32'h55);

        send_frame(8'h3C, 64, 1'b1);
        cyc(20);
        send_frame(8'hA3, 64, 1'b0);
        cyc(80);
        drain(300);
        check_eq("ferr_dout_kept", {24'b0, rx_dout}, 32'h3C);

        // Reset in the middle of data bit 4.
        rx = 1'b0;
        cyc(64);
        for (int i = 0; i < 4; i++) begin
            rx = abort_d[i];
            cyc(64);
        end
        rx = abort_d[4];
        cyc(32);
        check_eq("abort_busy_pre", {31'b0, rx_busy}, 32'd1);
        PRESETn = 1'b0;
        rx      = 1'b1;
        cyc(4);
        exp_dout = 8'h00;
        check_eq("abort_rst_busy", {31'b0, rx_busy}, 32'd0);
        check_eq("abort_rst_dout", {24'b0, rx_dout}, 32'd0);
        PRESETn = 1'b1;
        cyc(700);
        check_eq("abort_no_resume", {31'b0, rx_busy}, 32'd0);
        send_frame(8'h81, 64, 1'b1);
        drain(300);
        check_eq("dout_81", {24'b0, rx_dout}, 32'h81);

        send_frame(8'h00, 64, 1'b1);
        send_frame(8'hFF, 64, 1'b1);
        drain(300);
        check_eq("dout_ff", {24'b0, rx_dout}, 32'hFF);

        cyc(50);
        send_frame(8'h5A, 62, 1'b1);
        cyc(40);
        drain(300);
        send_frame(8'hA5, 64, 1'b1);
        drain(300);
        send_frame(8'h5A, 66, 1'b1);
        cyc(40);
        drain(300);
        check_eq("dout_5a_slow", {24'b0, rx_dout}, 32'h5A);

        // With s_tick stopped the FSM must hold in START indefinitely.
        rx = 1'b0;
        cyc(8);
        tick_en = 1'b0;
        cyc(1000);
        check_eq("freeze_busy", {31'b0, rx_busy}, 32'd1);
        rx = 1'b1;
        cyc(4);
        tick_en = 1'b1;
        cyc(80);
        check_eq("freeze_release", {31'b0, rx_busy}, 32'd0);
        check_eq("freeze_dout", {24'b0, rx_dout}, 32'h5A);

        cyc(20);
        check_eq("sb_final", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
